// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle ARM-subset control unit (FSM, condition check, NZCV flags).
// Define MULTICYCLE_CTRL_CMP_EN to decode CMP as a flag-only subtract with no register write-back.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUControl,
   output logic [3:0] State,
   output logic [3:0] Flags
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, UNKNOWN = 4'd10
   } state_t;
   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_ex_r_q, cond_ex_r_d;
   logic       next_pc, reg_w, mem_w, branch, alu_op, no_write, cond_ex, pcs;
   logic       n, z, c, v;
   logic [1:0] flag_w;
   assign {n, z, c, v} = flags_q;
   always_comb begin
      state_d = UNKNOWN;
      next_pc = 1'b0;
      reg_w = 1'b0;
      mem_w = 1'b0;
      branch = 1'b0;
      alu_op = 1'b0;
      IRWrite = 1'b0;
      AdrSrc = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'b00;
      ResultSrc = 2'b00;
      case (state_q)
         FETCH: begin
            state_d = DECODE;
            IRWrite = 1'b1;
            next_pc = 1'b1;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            state_d = Op == 2'b01 ? MEMADR : Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                      Op == 2'b10 ? BRANCH : UNKNOWN;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: begin
            state_d = Funct[0] ? MEMRD : MEMWR;
            ALUSrcB = 2'b01;
         end
         MEMRD: begin
            state_d = MEMWB;
            AdrSrc = 1'b1;
         end
         MEMWB: begin
            state_d = FETCH;
            ResultSrc = 2'b01;
            reg_w = 1'b1;
         end
         MEMWR: begin
            state_d = FETCH;
            AdrSrc = 1'b1;
            mem_w = 1'b1;
         end
         EXECR: begin
            state_d = ALUWB;
            alu_op = 1'b1;
         end
         EXECI: begin
            state_d = ALUWB;
            ALUSrcB = 2'b01;
            alu_op = 1'b1;
         end
         ALUWB: begin
            state_d = FETCH;
            reg_w = 1'b1;
         end
         BRANCH: begin
            state_d = FETCH;
            ALUSrcB = 2'b01;
            ResultSrc = 2'b10;
            branch = 1'b1;
         end
         default: state_d = UNKNOWN;
      endcase
   end
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = n == v;
         4'b1011: cond_ex = n != v;
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end
   always_comb begin
      ALUControl = 2'b00;
      no_write = 1'b0;
      if (alu_op)
         case (Funct[4:1])
            4'b0010: ALUControl = 2'b01;
            4'b0000: ALUControl = 2'b10;
            4'b1100: ALUControl = 2'b11;
`ifdef MULTICYCLE_CTRL_CMP_EN
            4'b1010: ALUControl = 2'b01;
`endif
            default: ALUControl = 2'b00;
         endcase
`ifdef MULTICYCLE_CTRL_CMP_EN
      // Write-back happens in ALUWB where alu_op is low, so decode CMP from the held instruction
      no_write = Op == 2'b00 && Funct[4:1] == 4'b1010;
`endif
   end
   always_comb begin
      flag_w[1] = alu_op & Funct[0];
      flag_w[0] = flag_w[1] & ~ALUControl[1];
      cond_ex_r_d = state_q == DECODE ? cond_ex : cond_ex_r_q;
      flags_d = {flag_w[1] && cond_ex_r_q ? ALUFlags[3:2] : flags_q[3:2],
                 flag_w[0] && cond_ex_r_q ? ALUFlags[1:0] : flags_q[1:0]};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= FETCH;
         flags_q <= 4'b0000;
         cond_ex_r_q <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cond_ex_r_q <= cond_ex_r_d;
      end
   assign pcs = branch | (reg_w & (Rd == 4'd15));
   assign PCWrite = next_pc | (pcs & cond_ex_r_q);
   assign MemWrite = mem_w & cond_ex_r_q;
   assign RegWrite = reg_w & cond_ex_r_q & ~no_write;
   assign ImmSrc = Op;
   assign RegSrc = {Op == 2'b01, Op == 2'b10};
   assign State = state_q;
   assign Flags = flags_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] Cond = 4'b1110, Rd = 4'd0, ALUFlags = 4'd0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'd0;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
   logic [3:0] State, Flags;
   int checks = 0;
   int failures = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State), .Flags(Flags)
   );

   always #5 clk = ~clk;

   task automatic set_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] c,
                            input logic [3:0] rd, input logic [3:0] af);
      Op = op; Funct = f; Cond = c; Rd = rd; ALUFlags = af;
   endtask

   // Leaves the DUT in FETCH at a falling edge, flags cleared.
   task automatic do_reset;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      set_instr(2'b01, 6'd0, 4'b1110, 4'd0, 4'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (State !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", State); end
      checks++; if ({PCWrite, IRWrite, ALUSrcA} !== 3'b111) begin failures++; $display("FAIL reset_pc_ir_srca got=%b exp=111", {PCWrite, IRWrite, ALUSrcA}); end
      checks++; if ({ALUSrcB, ResultSrc} !== 4'b1010) begin failures++; $display("FAIL reset_srcb_res got=%b exp=1010", {ALUSrcB, ResultSrc}); end
      checks++; if ({MemWrite, RegWrite, AdrSrc, ALUControl} !== 5'b0) begin failures++; $display("FAIL reset_others got=%b exp=00000", {MemWrite, RegWrite, AdrSrc, ALUControl}); end
      checks++; if ({ImmSrc, RegSrc} !== 4'b0110) begin failures++; $display("FAIL reset_imm_regsrc got=%b exp=0110", {ImmSrc, RegSrc}); end
      checks++; if (Flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
      reset = 1'b0;
      checks++; if (State !== 4'd0) begin failures++; $display("FAIL release_state got=%0d exp=0", State); end
      @(negedge clk);
      checks++; if (State !== 4'd1) begin failures++; $display("FAIL first_edge_state got=%0d exp=1", State); end
   endtask

   task automatic test_ldr;
      logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      logic [1:0] er [5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
      do_reset;
      set_instr(2'b01, 6'b011001, 4'b1110, 4'd1, 4'd0);
      for (int i = 0; i < 5; i++) begin
         checks++; if (State !== es[i]) begin failures++; $display("FAIL ldr_state[%0d] got=%0d exp=%0d", i, State, es[i]); end
         checks++; if (RegWrite !== (i == 4)) begin failures++; $display("FAIL ldr_regwrite[%0d] got=%b", i, RegWrite); end
         checks++; if (AdrSrc !== (i == 3)) begin failures++; $display("FAIL ldr_adrsrc[%0d] got=%b", i, AdrSrc); end
         checks++; if (ResultSrc !== er[i]) begin failures++; $display("FAIL ldr_resultsrc[%0d] got=%b exp=%b", i, ResultSrc, er[i]); end
         checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL ldr_memwrite[%0d] got=%b exp=0", i, MemWrite); end
         @(negedge clk);
      end
      checks++; if (State !== 4'd0) begin failures++; $display("FAIL ldr_return got=%0d exp=0", State); end
   endtask

   task automatic test_str_not_taken;
      logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      do_reset;
      set_instr(2'b01, 6'b011000, 4'b0000, 4'd1, 4'd0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (State !== es[i]) begin failures++; $display("FAIL str0_state[%0d] got=%0d exp=%0d", i, State, es[i]); end
         checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL str0_memwrite[%0d] got=%b exp=0", i, MemWrite); end
         @(negedge clk);
      end
      checks++; if (State !== 4'd0) begin failures++; $display("FAIL str0_return got=%0d exp=0", State); end
   endtask

   task automatic test_subs_branch;
      logic [3:0] es [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
      logic [3:0] ss [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      logic [3:0] bs [3] = '{4'd0, 4'd1, 4'd9};
      do_reset;
      set_instr(2'b00, 6'b000101, 4'b1110, 4'd2, 4'b0100);
      for (int i = 0; i < 4; i++) begin
         checks++; if (State !== es[i]) begin failures++; $display("FAIL subs_state[%0d] got=%0d exp=%0d", i, State, es[i]); end
         checks++; if (Flags !== (i == 3 ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL subs_flags[%0d] got=%b", i, Flags); end
         checks++; if (RegWrite !== (i == 3)) begin failures++; $display("FAIL subs_regwrite[%0d] got=%b", i, RegWrite); end
         @(negedge clk);
      end
      set_instr(2'b01, 6'b011000, 4'b0000, 4'd1, 4'd0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (State !== ss[i]) begin failures++; $display("FAIL str1_state[%0d] got=%0d exp=%0d", i, State, ss[i]); end
         checks++; if (MemWrite !== (i == 3)) begin failures++; $display("FAIL str1_memwrite[%0d] got=%b", i, MemWrite); end
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         set_instr(2'b10, 6'd0, k == 0 ? 4'b0000 : 4'b0001, 4'd0, 4'd0);
         for (int i = 0; i < 3; i++) begin
            checks++; if (State !== bs[i]) begin failures++; $display("FAIL b%0d_state[%0d] got=%0d exp=%0d", k, i, State, bs[i]); end
            checks++; if (PCWrite !== (i == 0 || (i == 2 && k == 0))) begin failures++; $display("FAIL b%0d_pcwrite[%0d] got=%b", k, i, PCWrite); end
            @(negedge clk);
         end
      end
      checks++; if (State !== 4'd0) begin failures++; $display("FAIL b_return got=%0d exp=0", State); end
   endtask

   task automatic test_add_pc;
      logic [3:0] es [4] = '{4'd0, 4'd1, 4'd7, 4'd8};
      do_reset;
      set_instr(2'b00, 6'b101000, 4'b1110, 4'd15, 4'b1111);
      for (int i = 0; i < 4; i++) begin
         checks++; if (State !== es[i]) begin failures++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, State, es[i]); end
         if (i == 2) begin
            checks++; if ({ALUSrcB, ALUControl} !== 4'b0100) begin failures++; $display("FAIL add_execi got=%b exp=0100", {ALUSrcB, ALUControl}); end
         end
         if (i == 3) begin
            checks++; if ({RegWrite, PCWrite} !== 2'b11) begin failures++; $display("FAIL add_pc_wb got=%b exp=11", {RegWrite, PCWrite}); end
         end
         @(negedge clk);
      end
      checks++; if (Flags !== 4'b0000) begin failures++; $display("FAIL add_noflags got=%b exp=0000", Flags); end
   endtask

   task automatic test_alu_decode;
      logic [5:0] fn [4] = '{6'b011001, 6'b000000, 6'b000101, 6'b010101};
      logic [3:0] cd [4] = '{4'b1110, 4'b1110, 4'b0000, 4'b1110};
      logic [3:0] af [4] = '{4'b1011, 4'b0101, 4'b1111, 4'b0110};
      logic [3:0] ef [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0110};
`ifdef MULTICYCLE_CTRL_CMP_EN
      logic [1:0] ec [4] = '{2'b11, 2'b10, 2'b01, 2'b01};
      logic       ew [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
      logic [1:0] ec [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
      logic       ew [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
`endif
      do_reset;
      for (int k = 0; k < 4; k++) begin
         set_instr(2'b00, fn[k], cd[k], 4'd3, af[k]);
         repeat (2) @(negedge clk);
         checks++; if (State !== 4'd6) begin failures++; $display("FAIL alu%0d_state got=%0d exp=6", k, State); end
         checks++; if (ALUControl !== ec[k]) begin failures++; $display("FAIL alu%0d_control got=%b exp=%b", k, ALUControl, ec[k]); end
         @(negedge clk);
         checks++; if (RegWrite !== ew[k]) begin failures++; $display("FAIL alu%0d_regwrite got=%b exp=%b", k, RegWrite, ew[k]); end
         @(negedge clk);
         checks++; if (Flags !== ef[k]) begin failures++; $display("FAIL alu%0d_flags got=%b exp=%b", k, Flags, ef[k]); end
      end
   endtask

   task automatic test_cond;
      logic [3:0] fl [16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                              4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0100};
      logic [3:0] cd [16] = '{4'b1100, 4'b1101, 4'b1000, 4'b0010, 4'b1011, 4'b1010, 4'b0100, 4'b0101,
                              4'b1000, 4'b1001, 4'b0011, 4'b0110, 4'b0111, 4'b1111, 4'b1100, 4'b1101};
      logic       ex [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset;
      for (int k = 0; k < 16; k++) begin
         set_instr(2'b00, 6'b000101, 4'b1110, 4'd1, fl[k]);
         repeat (4) @(negedge clk);
         set_instr(2'b10, 6'd0, cd[k], 4'd0, 4'd0);
         repeat (2) @(negedge clk);
         checks++; if ({State, PCWrite} !== {4'd9, ex[k]}) begin failures++; $display("FAIL cond%0d flags=%b cond=%b got state=%0d pcwrite=%b exp pcwrite=%b", k, fl[k], cd[k], State, PCWrite, ex[k]); end
         @(negedge clk);
      end
   endtask

   task automatic test_unknown;
      do_reset;
      set_instr(2'b11, 6'd0, 4'b1110, 4'd15, 4'b1111);
      @(negedge clk);
      checks++; if (State !== 4'd1) begin failures++; $display("FAIL unk_decode got=%0d exp=1", State); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (State !== 4'd10) begin failures++; $display("FAIL unk_state[%0d] got=%0d exp=10", i, State); end
         checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0) begin failures++; $display("FAIL unk_we[%0d] got=%b exp=0000", i, {PCWrite, IRWrite, MemWrite, RegWrite}); end
         checks++; if (Flags !== 4'b0000) begin failures++; $display("FAIL unk_flags[%0d] got=%b exp=0000", i, Flags); end
      end
      #2 reset = 1'b1;
      #1;
      checks++; if ({State, PCWrite} !== {4'd0, 1'b1}) begin failures++; $display("FAIL unk_async_reset got state=%0d pcwrite=%b exp state=0 pcwrite=1", State, PCWrite); end
      reset = 1'b0;
      set_instr(2'b00, 6'd0, 4'b1110, 4'd0, 4'd0);
      @(negedge clk);
      checks++; if (State !== 4'd1) begin failures++; $display("FAIL unk_after_reset got=%0d exp=1", State); end
   endtask

   task automatic test_async_flags;
      do_reset;
      set_instr(2'b00, 6'b000101, 4'b1110, 4'd2, 4'b1100);
      repeat (3) @(negedge clk);
      checks++; if ({State, Flags} !== {4'd8, 4'b1100}) begin failures++; $display("FAIL async_pre got state=%0d flags=%b exp state=8 flags=1100", State, Flags); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({State, Flags} !== 8'h00) begin failures++; $display("FAIL async_mid got state=%0d flags=%b exp state=0 flags=0000", State, Flags); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset;
      test_ldr;
      test_str_not_taken;
      test_subs_branch;
      test_add_pc;
      test_alu_decode;
      test_cond;
      test_unknown;
      test_async_flags;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
